// File: rtl/console_uart_mmio.sv
// Memory-mapped 8N1 UART console: TX/RX FIFOs, data/status registers, combinational read path.
// Optional build macro CONSOLE_LOOPBACK_EN routes internal TX into the RX synchroniser and parks the TX pin high.
module console_uart_mmio #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SEL_DATA,
  input  logic        SEL_STAT,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  WriteData,
  output logic [31:0] ReadData,
  input  logic        RX,
  output logic        TX,
  output logic        RX_IRQ
);
  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  state_t        tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]    tx_bits, rx_bits;
  logic [7:0]    tx_shift, rx_shift;
  logic          tx_line, tx_bit_end, rx_bit_end;
  logic          rx_src, rx_p0, rx_p1, rx_p2;
  logic          rx_stop_ok, rx_stop_bad, ovr, ferr, flag_clr, txidle;

  // Full when the pointers differ only in the wrap bit.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign tx_bit_end = (tx_cnt == DIV_LAST);
  assign rx_bit_end = (rx_cnt == DIV_LAST);
  assign tx_pop     = !tx_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_bit_end));
  assign tx_push    = SEL_DATA && MemWrite && (!tx_full || tx_pop);
  assign rx_pop     = SEL_DATA && MemRead && !rx_empty;
  assign rx_stop_ok  = (rx_state == STOP) && rx_bit_end && rx_p1;
  assign rx_stop_bad = (rx_state == STOP) && rx_bit_end && !rx_p1;
  assign rx_push    = rx_stop_ok && (!rx_full || rx_pop);
  assign flag_clr   = SEL_STAT && MemRead;
  assign txidle     = tx_empty && (tx_state == IDLE);
  assign RX_IRQ     = !rx_empty;

`ifdef CONSOLE_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = RX;
  assign rx_src    = tx_line;
  assign TX        = 1'b1;
`else
  assign rx_src    = RX;
  assign TX        = tx_line;
`endif

  always_comb begin
    ReadData = '0;
    if (SEL_DATA)
      ReadData = {24'b0, rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]]};
    else if (SEL_STAT)
      ReadData = {27'b0, txidle, ferr, ovr, !tx_full, !rx_empty};
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= WriteData;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
    if (tx_pop)
      tx_shift <= tx_mem[tx_rp[AW-1:0]];
    else if (tx_state == DATA && tx_bit_end)
      tx_shift <= {1'b0, tx_shift[7:1]};
    if (rx_state == DATA && rx_bit_end)
      rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      // A new error in the clearing cycle keeps its flag set.
      ovr   <= (ovr && !flag_clr) || (rx_stop_ok && rx_full && !rx_pop);
      ferr  <= (ferr && !flag_clr) || rx_stop_bad;
      rx_p0 <= rx_src;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (!tx_empty) begin
          tx_state <= START;
          tx_line  <= 1'b0;
          tx_cnt   <= '0;
        end
        START: if (tx_bit_end) begin
          tx_state <= DATA;
          tx_line  <= tx_shift[0];
          tx_cnt   <= '0;
          tx_bits  <= '0;
        end else tx_cnt <= tx_cnt + 1'b1;
        DATA: if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_bits == 3'd7) begin
            tx_state <= STOP;
            tx_line  <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 1'b1;
            tx_line <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        STOP: if (tx_bit_end) begin
          tx_cnt <= '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!tx_empty) begin
            tx_state <= START;
            tx_line  <= 1'b0;
          end else tx_state <= IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
    end else begin
      case (rx_state)
        IDLE: if (!rx_p1 && rx_p2) begin
          rx_state <= START;
          rx_cnt   <= '0;
        end
        START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bits  <= '0;
          rx_state <= rx_p1 ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        DATA: if (rx_bit_end) begin
          rx_cnt <= '0;
          if (rx_bits == 3'd7) rx_state <= STOP;
          else rx_bits <= rx_bits + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        STOP: if (rx_bit_end) begin
          rx_cnt   <= '0;
          rx_state <= IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  end
endmodule
